// File: rtl/vcr_host.sv
// -----------------------------------------------------------------------------
// vcr_host
// Initiator for the 9-line Vendor Command/Request bus (8-bit bidirectional
// address/data plus one strobe). Each accepted command runs one complete
// transaction: address strobe, cmd_wr_len write strobes, then cmd_rd_len
// read strobes. The bus value is set up before every rising strobe. Read
// bytes are sampled on the same edge that raises the strobe.
//
// Ports
//   IFCLK          sole clock
//   RESET          synchronous, active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only when idle)
//   cmd_addr, cmd_wr_len, cmd_rd_len   command fields
//   wr_data/wr_data_valid    write byte source
//   wr_data_ready            one-cycle pulse after a write byte is taken
//   rd_data/rd_data_valid    captured read byte and its one-cycle pulse
//   done                     one-cycle pulse at transaction end
//   busy, cs                 high from accept through the done cycle
//   vcr_inout                shared address/data lines, Z when released
//   vcr_clk_out              registered strobe
// -----------------------------------------------------------------------------
module vcr_host #(
    parameter int SETUP_CYCLES = 4,
    parameter int HIGH_CYCLES  = 4,
    parameter int LOW_CYCLES   = 4,
    parameter int TURN_CYCLES  = 4
) (
    input  logic       IFCLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [3:0] cmd_wr_len,
    input  logic [3:0] cmd_rd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_data_valid,
    output logic       wr_data_ready,
    output logic [7:0] rd_data,
    output logic       rd_data_valid,
    output logic       done,
    output logic       busy,
    output logic       cs,
    inout  wire  [7:0] vcr_inout,
    output logic       vcr_clk_out
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ADDR_SETUP = 4'd1,
        ST_STROBE_HI  = 4'd2,
        ST_STROBE_LO  = 4'd3,
        ST_WR_FETCH   = 4'd4,
        ST_WR_SETUP   = 4'd5,
        ST_TURN       = 4'd6,
        ST_RD_SETTLE  = 4'd7,
        ST_DONE       = 4'd8
    } state_t;

    // Timer reload values: the timer counts N-1 down to 0 in each timed state.
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] HIGH_LOAD  = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] LOW_LOAD   = 8'(LOW_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD  = 8'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] wr_left_q, wr_left_d;
    logic [3:0] rd_left_q, rd_left_d;
    logic [7:0] bus_q, bus_d;
    logic       drive_en_q, drive_en_d;
    logic       vcr_clk_q, vcr_clk_d;
    logic       cs_q, cs_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_data_valid_q, rd_data_valid_d;
    logic       wr_data_ready_q, wr_data_ready_d;
    logic       timer_zero_s;

    // Bus driver: the host owns the lines only while drive_en_q is set.
    assign vcr_inout = drive_en_q ? bus_q : 8'hzz;

    assign cmd_ready     = cmd_ready_q & ~RESET;
    assign wr_data_ready = wr_data_ready_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign cs            = cs_q;
    assign vcr_clk_out   = vcr_clk_q;

    assign timer_zero_s = (timer_q == 8'd0);

    // Next-state, timer, counters and bus contents.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        wr_left_d       = wr_left_q;
        rd_left_d       = rd_left_q;
        bus_d           = bus_q;
        drive_en_d      = drive_en_q;
        rd_data_d       = rd_data_q;
        rd_data_valid_d = 1'b0;
        wr_data_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    wr_left_d  = cmd_wr_len;
                    rd_left_d  = cmd_rd_len;
                    bus_d      = cmd_addr;
                    drive_en_d = 1'b1;
                    timer_d    = SETUP_LOAD;
                    state_d    = ST_ADDR_SETUP;
                end else begin
                    drive_en_d = 1'b0;
                end
            end

            // All three lead into a rising strobe once the bus has settled.
            ST_ADDR_SETUP, ST_WR_SETUP, ST_RD_SETTLE: begin
                if (timer_zero_s) begin
                    state_d = ST_STROBE_HI;
                    timer_d = HIGH_LOAD;
                    if (state_q == ST_WR_SETUP) begin
                        wr_left_d = wr_left_q - 4'd1;
                    end else if (state_q == ST_RD_SETTLE) begin
                        // Sample edge coincides with the strobe rising.
                        rd_left_d       = rd_left_q - 4'd1;
                        rd_data_d       = vcr_inout;
                        rd_data_valid_d = 1'b1;
                    end else begin
                        wr_left_d = wr_left_q;
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            ST_STROBE_HI: begin
                if (timer_zero_s) begin
                    state_d = ST_STROBE_LO;
                    timer_d = LOW_LOAD;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            ST_STROBE_LO: begin
                if (!timer_zero_s) begin
                    timer_d = timer_q - 8'd1;
                end else if (wr_left_q != 4'd0) begin
                    state_d = ST_WR_FETCH;
                end else if (rd_left_q != 4'd0) begin
                    // Still driving means no read has happened yet, so the
                    // bus must be turned around before the first sample.
                    if (drive_en_q) begin
                        drive_en_d = 1'b0;
                        timer_d    = TURN_LOAD;
                        state_d    = ST_TURN;
                    end else begin
                        timer_d = SETUP_LOAD;
                        state_d = ST_RD_SETTLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end

            // Bus keeps its previous value while the write source stalls.
            ST_WR_FETCH: begin
                if (wr_data_valid) begin
                    bus_d           = wr_data;
                    wr_data_ready_d = 1'b1;
                    timer_d         = SETUP_LOAD;
                    state_d         = ST_WR_SETUP;
                end else begin
                    bus_d = bus_q;
                end
            end

            ST_TURN: begin
                if (timer_zero_s) begin
                    timer_d = SETUP_LOAD;
                    state_d = ST_RD_SETTLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            ST_DONE: begin
                drive_en_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                drive_en_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Status outputs follow the upcoming state so they are registered with it.
    always_comb begin
        cs_d        = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        vcr_clk_d   = (state_d == ST_STROBE_HI);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge IFCLK) begin
        if (RESET) begin
            state_q         <= ST_IDLE;
            timer_q         <= 8'd0;
            wr_left_q       <= 4'd0;
            rd_left_q       <= 4'd0;
            bus_q           <= 8'd0;
            drive_en_q      <= 1'b0;
            vcr_clk_q       <= 1'b0;
            cs_q            <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            cmd_ready_q     <= 1'b0;
            rd_data_q       <= 8'd0;
            rd_data_valid_q <= 1'b0;
            wr_data_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            wr_left_q       <= wr_left_d;
            rd_left_q       <= rd_left_d;
            bus_q           <= bus_d;
            drive_en_q      <= drive_en_d;
            vcr_clk_q       <= vcr_clk_d;
            cs_q            <= cs_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            cmd_ready_q     <= cmd_ready_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
            wr_data_ready_q <= wr_data_ready_d;
        end
    end

endmodule

// File: tb/tb_vcr_host.sv
// -----------------------------------------------------------------------------
// tb_vcr_host
// Directed bench for vcr_host with a small behavioural VCR responder:
//   0x80 address only, 0x82 app_mode write, 0x88 echo (read = write ^ 0x5A),
//   0x8A FPGA_ID read (returns 0x03).
// -----------------------------------------------------------------------------
module tb_vcr_host;

    logic       IFCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [3:0] cmd_wr_len = 4'd0;
    logic [3:0] cmd_rd_len = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_data_valid = 1'b0;
    logic       cmd_ready, wr_data_ready, rd_data_valid, done, busy, cs, vcr_clk_out;
    logic [7:0] rd_data;
    wire  [7:0] vcr_bus;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    vcr_host dut (
        .IFCLK(IFCLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wr_len(cmd_wr_len), .cmd_rd_len(cmd_rd_len),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .done(done), .busy(busy), .cs(cs),
        .vcr_inout(vcr_bus), .vcr_clk_out(vcr_clk_out)
    );

    always #5 IFCLK = ~IFCLK;

    // Edge counter; read at negedges it names the most recent rising edge.
    always @(posedge IFCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- responder and monitor ----------------
    logic [7:0] resp_data = 8'h00;
    bit         resp_oe = 1'b0;
    int         r_idx = 0;
    int         r_rd = 0;
    logic [7:0] r_addr = 8'h00;
    logic [7:0] wbuf [0:15];
    logic [7:0] app_mode = 8'h00;
    bit         prev_strobe = 1'b0;
    bit         prev_z = 1'b1;
    bit         contention = 1'b0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         rd_cnt = 0;
    int         rel_cyc = -1;
    logic [7:0] rd_log [$];

    assign vcr_bus = (resp_oe && cs) ? resp_data : 8'hzz;

    function automatic logic [7:0] resp_value(input logic [7:0] a, input int k);
        logic [3:0] ki;
        ki = k[3:0];
        if (a == 8'h8A) return 8'h03;
        else if (a == 8'h88) return wbuf[ki] ^ 8'h5A;
        else return 8'hEE;
    endfunction

    always @(negedge IFCLK) begin
        bit z_now;
        z_now = (vcr_bus === 8'hzz);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_data_valid) begin
            rd_cnt++;
            rd_log.push_back(rd_data);
        end
        if (cs && z_now && !prev_z) rel_cyc = cyc;
        prev_z = z_now;
        if (resp_oe && cs && (vcr_bus !== resp_data)) contention = 1'b1;
        if (!cs) begin
            resp_oe = 1'b0;
            r_idx   = 0;
            r_rd    = 0;
        end else begin
            if (vcr_clk_out && !prev_strobe) begin
                if (r_idx == 0) r_addr = vcr_bus;
                else if (resp_oe) r_rd++;
                else begin
                    wbuf[(r_idx - 1) % 16] = vcr_bus;
                    if (r_addr == 8'h82) app_mode = vcr_bus;
                end
                r_idx++;
            end
            // Take the bus only once the host has visibly released it.
            if (!resp_oe && r_idx > 0 && z_now) resp_oe = 1'b1;
            resp_data = resp_value(r_addr, r_rd);
        end
        prev_strobe = vcr_clk_out;
    end

    // ---------------- write byte source ----------------
    logic [7:0] wq [$];
    int         feed_from = 0;

    always @(negedge IFCLK) begin
        if (wr_data_ready && wq.size() > 0) void'(wq.pop_front());
        wr_data_valid = (wq.size() > 0) && (cyc >= feed_from);
        wr_data       = (wq.size() > 0) ? wq[0] : 8'h00;
    end

    // ---------------- helpers ----------------
    task automatic send_cmd(input logic [7:0] a, input logic [3:0] wl, input logic [3:0] rl,
                            output int acc);
        bit ok;
        ok = 1'b0;
        acc = 0;
        cmd_addr = a; cmd_wr_len = wl; cmd_rd_len = rl; cmd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) begin
                @(negedge IFCLK);
                acc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge IFCLK);
        end
        cmd_valid = 1'b0;
        if (!ok) check_eq("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge IFCLK);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge IFCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_echo [4];
    logic [7:0] got_b;
    int acc, d0, r0;

    initial begin
        exp_echo = '{8'h5B, 8'h58, 8'h59, 8'h5E};
        repeat (3) @(posedge IFCLK);
        @(negedge IFCLK);
        RESET = 1'b0;
        repeat (3) @(negedge IFCLK);

        // Reset held two cycles while idle.
        RESET = 1'b1;
        repeat (2) @(negedge IFCLK);
        check_eq("rst_bus_z", 32'(vcr_bus === 8'hzz), 32'd1);
        check_eq("rst_strobe", 32'(vcr_clk_out), 32'd0);
        check_eq("rst_cs", 32'(cs), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_data_valid), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_data_ready), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        RESET = 1'b0;
        #1;
        check_eq("cmd_ready_at_release", 32'(cmd_ready), 32'd0);
        @(negedge IFCLK);
        check_eq("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        // Address-only 0x80.
        send_cmd(8'h80, 4'd0, 4'd0, acc);
        check_eq("a80_bus_c0", 32'(vcr_bus), 32'h80);
        check_eq("a80_busy", 32'(busy), 32'd1);
        check_eq("a80_cs", 32'(cs), 32'd1);
        check_eq("a80_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        wait_cyc(acc + 3);
        check_eq("a80_strobe_c3", 32'(vcr_clk_out), 32'd0);
        check_eq("a80_bus_c3", 32'(vcr_bus), 32'h80);
        wait_cyc(acc + 4);
        check_eq("a80_strobe_c4", 32'(vcr_clk_out), 32'd1);
        wait_cyc(acc + 7);
        check_eq("a80_strobe_c7", 32'(vcr_clk_out), 32'd1);
        wait_cyc(acc + 8);
        check_eq("a80_strobe_c8", 32'(vcr_clk_out), 32'd0);
        wait_done(40);
        check_eq("a80_done_latency", 32'(done_cyc - acc), 32'd12);
        repeat (2) @(negedge IFCLK);
        check_eq("a80_bus_z_after", 32'(vcr_bus === 8'hzz), 32'd1);
        check_eq("a80_cs_after", 32'(cs), 32'd0);
        check_eq("a80_busy_after", 32'(busy), 32'd0);

        // Echo 0x88: write 01..04, read 4 bytes back.
        wq = '{8'h01, 8'h02, 8'h03, 8'h04};
        feed_from = 0;
        rd_log.delete();
        r0 = rd_cnt;
        contention = 1'b0;
        send_cmd(8'h88, 4'd4, 4'd4, acc);
        wait_done(200);
        check_eq("echo_done_latency", 32'(done_cyc - acc), 32'd116);
        check_eq("echo_rd_pulses", 32'(rd_cnt - r0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got_b = (i < rd_log.size()) ? rd_log[i] : 8'hFF;
            check_eq($sformatf("echo_rd%0d", i), 32'(got_b), 32'(exp_echo[i]));
        end
        check_eq("echo_no_contention", 32'(contention), 32'd0);
        repeat (2) @(negedge IFCLK);

        // FPGA_ID read 0x8A.
        rel_cyc = -1;
        r0 = rd_cnt;
        send_cmd(8'h8A, 4'd0, 4'd1, acc);
        wait_done(100);
        check_eq("id_rd_data", 32'(rd_data), 32'h03);
        check_eq("id_rd_pulses", 32'(rd_cnt - r0), 32'd1);
        check_eq("id_done_latency", 32'(done_cyc - acc), 32'd28);
        check_eq("id_release_cyc", 32'(rel_cyc - acc), 32'd12);
        repeat (2) @(negedge IFCLK);

        // Write 0x82 with a stalled source.
        wq = '{8'h07};
        feed_from = 1000000;
        send_cmd(8'h82, 4'd1, 4'd0, acc);
        feed_from = acc + 22;
        wait_cyc(acc + 17);
        check_eq("stall_strobe_low", 32'(vcr_clk_out), 32'd0);
        check_eq("stall_bus_hold", 32'(vcr_bus), 32'h82);
        wait_done(100);
        check_eq("stall_done_latency", 32'(done_cyc - acc), 32'd35);
        check_eq("stall_app_mode", 32'(app_mode), 32'h07);
        repeat (2) @(negedge IFCLK);

        // Reset during the second read byte of an echo.
        wq = '{8'h10, 8'h20, 8'h30, 8'h40};
        feed_from = 0;
        d0 = done_cnt;
        r0 = rd_cnt;
        send_cmd(8'h88, 4'd4, 4'd4, acc);
        wait_cyc(acc + 82);
        check_eq("mid_first_read", 32'(rd_cnt - r0), 32'd1);
        RESET = 1'b1;
        @(negedge IFCLK);
        check_eq("mid_rst_bus_z", 32'(vcr_bus === 8'hzz), 32'd1);
        check_eq("mid_rst_strobe", 32'(vcr_clk_out), 32'd0);
        check_eq("mid_rst_cs", 32'(cs), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_rd_data", 32'(rd_data), 32'd0);
        RESET = 1'b0;
        repeat (20) @(negedge IFCLK);
        check_eq("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("mid_rst_no_more_reads", 32'(rd_cnt - r0), 32'd1);

        r0 = rd_cnt;
        send_cmd(8'h8A, 4'd0, 4'd1, acc);
        wait_done(100);
        check_eq("post_rst_id_data", 32'(rd_data), 32'h03);
        check_eq("post_rst_id_pulses", 32'(rd_cnt - r0), 32'd1);
        check_eq("post_rst_id_latency", 32'(done_cyc - acc), 32'd28);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
